// File: rtl/sorting_feeder.sv
// Packet buffer in front of the sorter: collects one valid/ready packet, then
// replays it as a gap-free val/sop/eop burst once the sorter reports idle.
module sorting_feeder #(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 3
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [DWIDTH-1:0] s_data_i,
    input  logic              s_valid_i,
    input  logic              s_last_i,
    output logic              s_ready_o,
    input  logic              sort_busy_i,
    output logic [DWIDTH-1:0] data_o,
    output logic              sop_o,
    output logic              eop_o,
    output logic              val_o,
    output logic              drop_o
);

    localparam int              DEPTH    = 2 ** AWIDTH;
    localparam logic [AWIDTH:0] ONE      = (AWIDTH + 1)'(1);
    localparam logic [AWIDTH:0] DEPTH_W  = (AWIDTH + 1)'(DEPTH);
    localparam logic [AWIDTH:0] FULL_IDX = (AWIDTH + 1)'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_DROP = 2'd1,
        ST_WAIT = 2'd2,
        ST_SEND = 2'd3
    } state_e;

    state_e            state_q;
    logic [AWIDTH:0]   wcnt_q;
    logic [AWIDTH:0]   rcnt_q;
    logic [AWIDTH:0]   len_q;
    logic              s_ready_q;
    logic              val_q;
    logic              sop_q;
    logic              eop_q;
    logic              drop_q;
    logic [DWIDTH-1:0] data_q;

    logic [DWIDTH-1:0] mem [DEPTH];

    logic              accept;
    logic              mem_we;
    logic [AWIDTH:0]   wcnt_d;
    logic [AWIDTH:0]   rcnt_d;

    // Input handshake: a word transfers on a rising edge where s_valid_i and
    // s_ready_o are both high; s_last_i is meaningful only on that edge.
    assign accept = s_valid_i && s_ready_q;
    assign mem_we = accept && (state_q == ST_FILL);
    assign wcnt_d = wcnt_q + ONE;
    assign rcnt_d = rcnt_q + ONE;

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[wcnt_q[AWIDTH-1:0]] <= s_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_FILL;
            wcnt_q    <= '0;
            rcnt_q    <= '0;
            len_q     <= '0;
            s_ready_q <= 1'b0;
            val_q     <= 1'b0;
            sop_q     <= 1'b0;
            eop_q     <= 1'b0;
            drop_q    <= 1'b0;
            data_q    <= '0;
        end else begin
            drop_q <= 1'b0;
            case (state_q)
                ST_FILL: begin
                    s_ready_q <= 1'b1;
                    if (accept) begin
                        wcnt_q <= wcnt_d;
                        if (s_last_i) begin
                            len_q     <= wcnt_d;
                            s_ready_q <= 1'b0;
                            state_q   <= ST_WAIT;
                        end else if (wcnt_q == FULL_IDX) begin
                            len_q   <= DEPTH_W;
                            state_q <= ST_DROP;
                        end
                    end
                end
                ST_DROP: begin
                    if (accept && s_last_i) begin
                        drop_q    <= 1'b1;
                        s_ready_q <= 1'b0;
                        state_q   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Word 0 leaves on the same edge the sorter is seen idle,
                    // so the read pointer continues from word 1.
                    if (!sort_busy_i) begin
                        val_q   <= 1'b1;
                        sop_q   <= 1'b1;
                        eop_q   <= (len_q == ONE);
                        data_q  <= mem[0];
                        rcnt_q  <= ONE;
                        state_q <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (eop_q) begin
                        val_q     <= 1'b0;
                        sop_q     <= 1'b0;
                        eop_q     <= 1'b0;
                        data_q    <= '0;
                        wcnt_q    <= '0;
                        s_ready_q <= 1'b1;
                        state_q   <= ST_FILL;
                    end else begin
                        sop_q  <= 1'b0;
                        eop_q  <= (rcnt_q == len_q - ONE);
                        data_q <= mem[rcnt_q[AWIDTH-1:0]];
                        rcnt_q <= rcnt_d;
                    end
                end
                default: state_q <= ST_FILL;
            endcase
        end
    end

    assign s_ready_o = s_ready_q;
    assign val_o     = val_q;
    assign sop_o     = sop_q;
    assign eop_o     = eop_q;
    assign drop_o    = drop_q;
    assign data_o    = data_q;

endmodule

// File: tb/tb_sorting_feeder.sv
// Self-checking bench for sorting_feeder: table vectors, hand sequences for
// busy/reset corners, and random packets against a packet-level model.
`timescale 1ns/1ps
module tb_sorting_feeder;

    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 2 ** AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] s_data_i;
    logic          s_valid_i;
    logic          s_last_i;
    logic          s_ready_o;
    logic          sort_busy_i;
    logic [DW-1:0] data_o;
    logic          sop_o;
    logic          eop_o;
    logic          val_o;
    logic          drop_o;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] exp_q[$];
    int            exp_len_q[$];
    logic [DW-1:0] pkt[16];
    int            burst_idx      = 0;
    bit            in_burst       = 0;
    int            last_burst_len = 0;
    int            drop_cnt       = 0;
    bit            mon_en         = 0;

    typedef struct {
        int          len;
        int          gap_mode;
        int          hold;
        logic [7:0]  base;
        int          exp_len;
        int          exp_drop;
    } vec_t;

    vec_t vecs[7];

    sorting_feeder #(.DWIDTH(DW), .AWIDTH(AW)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .s_data_i    (s_data_i),
        .s_valid_i   (s_valid_i),
        .s_last_i    (s_last_i),
        .s_ready_o   (s_ready_o),
        .sort_busy_i (sort_busy_i),
        .data_o      (data_o),
        .sop_o       (sop_o),
        .eop_o       (eop_o),
        .val_o       (val_o),
        .drop_o      (drop_o)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Scoreboard: every output cycle is checked against the expected queue.
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            if (val_o) begin
                check("ready_low_in_burst", 32'(s_ready_o), 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 32'(val_o), 32'd0);
                end else begin
                    check("burst_data", 32'(data_o), 32'(exp_q.pop_front()));
                    check("burst_sop", 32'(sop_o), 32'(burst_idx == 0));
                    check("burst_eop", 32'(eop_o), 32'(burst_idx + 1 == exp_len_q[0]));
                    burst_idx++;
                    in_burst = 1;
                    if (burst_idx == exp_len_q[0]) begin
                        void'(exp_len_q.pop_front());
                        last_burst_len = burst_idx;
                        burst_idx      = 0;
                        in_burst       = 0;
                    end
                end
            end else begin
                check("gap_in_burst", 32'(in_burst), 32'd0);
                in_burst = 0;
                check("idle_outputs_zero", 32'({data_o, sop_o, eop_o}), 32'd0);
            end
            if (drop_o) drop_cnt++;
        end
    end

    task automatic flush_model();
        exp_q.delete();
        exp_len_q.delete();
        in_burst  = 0;
        burst_idx = 0;
    endtask

    // Packet-level model: at most DEPTH words survive, drop if longer.
    task automatic push_expected(input int len);
        int blen;
        blen = (len > DEPTH) ? DEPTH : len;
        for (int j = 0; j < blen; j++) exp_q.push_back(pkt[j]);
        exp_len_q.push_back(blen);
    endtask

    task automatic send_packet(input int len, input int gap_mode, input int hold);
        int blen;
        int gap;
        int waits;
        int cnt;
        bit rdy;
        blen = (len > DEPTH) ? DEPTH : len;
        for (int i = 0; i < len; i++) begin
            gap = 0;
            if (i != 0 && gap_mode == 1) gap = 1;
            if (i != 0 && gap_mode == 2) gap = $urandom_range(0, 2);
            repeat (gap) begin
                @(negedge clk);
                s_valid_i = 1'b0;
                s_last_i  = 1'b0;
                s_data_i  = 8'($urandom);
            end
            @(negedge clk);
            s_valid_i = 1'b1;
            s_data_i  = pkt[i];
            s_last_i  = (i == len - 1);
            if (i == len - 1 && hold > 0) sort_busy_i = 1'b1;
            rdy   = s_ready_o;
            waits = 0;
            while (!rdy && waits < 100) begin
                @(negedge clk);
                rdy = s_ready_o;
                waits++;
            end
            if (!rdy) check("ready_timeout", 32'(s_ready_o), 32'd1);
            @(posedge clk);
        end
        #1;
        check("ready_low_after_last", 32'(s_ready_o), 32'd0);
        check("drop_pulse", 32'(drop_o), 32'(len > DEPTH));
        push_expected(len);
        @(negedge clk);
        s_valid_i = 1'b0;
        s_last_i  = 1'b0;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            #1;
            check("held_while_busy", 32'(val_o), 32'd0);
        end
        if (hold > 0) begin
            @(negedge clk);
            sort_busy_i = 1'b0;
        end
        @(posedge clk);
        #1;
        check("sop_latency", 32'({val_o, sop_o}), 32'd3);
        if (hold > 0) sort_busy_i = 1'b1;
        cnt = 1;
        while (val_o && cnt <= 2 * DEPTH) begin
            @(posedge clk);
            #1;
            if (val_o) cnt++;
        end
        check("burst_terminates", 32'(val_o), 32'd0);
        check("burst_length", 32'(cnt), 32'(blen));
        check("ready_back_at_val_fall", 32'(s_ready_o), 32'd1);
        sort_busy_i = 1'b0;
    endtask

    task automatic drive_words(input int n, input bit last_final);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("ready_in_fill", 32'(s_ready_o), 32'd1);
            s_valid_i = 1'b1;
            s_data_i  = pkt[i];
            s_last_i  = last_final && (i == n - 1);
            @(posedge clk);
        end
    endtask

    task automatic async_reset_check(input string name);
        #2;
        rst_n = 1'b0;
        #1;
        check(name, 32'({s_ready_o, val_o, sop_o, eop_o, drop_o, data_o}), 32'd0);
        flush_model();
        s_valid_i   = 1'b0;
        s_last_i    = 1'b0;
        sort_busy_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_reset_release", 32'(s_ready_o), 32'd1);
    endtask

    initial begin
        rst_n       = 1'b0;
        s_data_i    = '0;
        s_valid_i   = 1'b0;
        s_last_i    = 1'b0;
        sort_busy_i = 1'b0;

        vecs[0] = '{len: 1,  gap_mode: 0, hold: 0, base: 8'hA5, exp_len: 1, exp_drop: 0};
        vecs[1] = '{len: 11, gap_mode: 0, hold: 0, base: 8'h00, exp_len: 8, exp_drop: 1};
        vecs[2] = '{len: 4,  gap_mode: 1, hold: 0, base: 8'h70, exp_len: 4, exp_drop: 0};
        vecs[3] = '{len: 8,  gap_mode: 0, hold: 0, base: 8'h80, exp_len: 8, exp_drop: 0};
        vecs[4] = '{len: 9,  gap_mode: 2, hold: 0, base: 8'h90, exp_len: 8, exp_drop: 1};
        vecs[5] = '{len: 7,  gap_mode: 1, hold: 3, base: 8'hC0, exp_len: 7, exp_drop: 0};
        vecs[6] = '{len: 2,  gap_mode: 0, hold: 1, base: 8'h11, exp_len: 2, exp_drop: 0};

        // Reset values and ready rising on the first edge after release
        #1;
        check("reset_outputs", 32'({s_ready_o, val_o, sop_o, eop_o, drop_o, data_o}), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready_before_first_edge", 32'(s_ready_o), 32'd0);
        @(posedge clk);
        #1;
        check("ready_first_edge", 32'(s_ready_o), 32'd1);
        mon_en = 1;

        // 5-word packet, sorter idle, then held busy for 20 cycles
        pkt[0] = 8'h30; pkt[1] = 8'h10; pkt[2] = 8'h50; pkt[3] = 8'h20; pkt[4] = 8'h40;
        send_packet(5, 0, 0);
        check("five_word_len", 32'(last_burst_len), 32'd5);
        send_packet(5, 0, 20);
        check("five_word_busy_len", 32'(last_burst_len), 32'd5);

        // Table vectors
        for (int v = 0; v < 7; v++) begin
            int d0;
            for (int i = 0; i < vecs[v].len; i++) pkt[i] = vecs[v].base + 8'(i);
            d0 = drop_cnt;
            send_packet(vecs[v].len, vecs[v].gap_mode, vecs[v].hold);
            check("vec_burst_len", 32'(last_burst_len), 32'(vecs[v].exp_len));
            check("vec_drop_count", 32'(drop_cnt - d0), 32'(vecs[v].exp_drop));
        end

        // Reset after 3 of 6 words: the aborted packet must never appear
        for (int i = 0; i < 6; i++) pkt[i] = 8'hE0 + 8'(i);
        drive_words(3, 1'b0);
        @(negedge clk);
        s_valid_i = 1'b0;
        async_reset_check("reset_mid_fill_outputs");
        for (int i = 0; i < 4; i++) pkt[i] = 8'h61 + 8'(i);
        send_packet(4, 0, 0);
        check("post_reset_len", 32'(last_burst_len), 32'd4);

        // Reset in the middle of a burst drops outputs immediately
        for (int i = 0; i < 6; i++) pkt[i] = 8'hB0 + 8'(i);
        drive_words(6, 1'b1);
        #1;
        push_expected(6);
        @(negedge clk);
        s_valid_i = 1'b0;
        s_last_i  = 1'b0;
        @(posedge clk);
        #1;
        check("burst_started", 32'(val_o), 32'd1);
        @(posedge clk);
        async_reset_check("reset_mid_burst_outputs");
        for (int i = 0; i < 3; i++) pkt[i] = 8'h5A + 8'(i);
        send_packet(3, 0, 0);

        // Random packets against the model
        for (int r = 0; r < 40; r++) begin
            int len;
            int d0;
            len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) pkt[i] = 8'($urandom);
            d0 = drop_cnt;
            send_packet(len, 2, $urandom_range(0, 3));
            check("rand_drop_count", 32'(drop_cnt - d0), 32'(len > DEPTH));
        end

        repeat (3) @(posedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
